count_window_monitor: RTL and testbench

- Downstream consumer of the dual 64-bit event counter (Cnt0 = raw events, Cnt1 = every-4th Slt event).
- Samples both running counts at fixed windows and computes per-window deltas.
- Compares each delta to a programmable threshold and presents a report record over a valid/ack handshake to the status/readout logic.

---
 rtl/cnt_mon_pkg.sv | 9 +
 rtl/count_window_monitor_if.sv | 7 +
 rtl/cnt_delta_sat.sv | 14 +
 rtl/count_window_monitor.sv | 98 +++++++++
 tb/tb_count_window_monitor.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/cnt_mon_pkg.sv
// cnt_mon_pkg: shared state type, default sizing and saturation helper for count_window_monitor.
package cnt_mon_pkg;
   typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
   localparam int DEF_DW = 32;
   localparam int unsigned DEF_WINDOW = 1000;
   function automatic logic [63:0] sat_max(input int dw);
      return (dw >= 64) ? '1 : (64'd1 << dw) - 64'd1;
   endfunction
endpackage

// File: rtl/count_window_monitor_if.sv
// count_window_monitor_if: report record handshake between the monitor and its consumer.
interface count_window_monitor_if #(parameter int DW = cnt_mon_pkg::DEF_DW);
   logic rpt_valid, rpt_ack, rpt_over0, rpt_over1, rpt_lost;
   logic [DW-1:0] rpt_delta0, rpt_delta1;
   modport master(output rpt_valid, rpt_delta0, rpt_delta1, rpt_over0, rpt_over1, rpt_lost, input rpt_ack);
   modport slave(input rpt_valid, rpt_delta0, rpt_delta1, rpt_over0, rpt_over1, rpt_lost, output rpt_ack);
endinterface

// File: rtl/cnt_delta_sat.sv
// cnt_delta_sat: 64-bit window delta; an upstream counter reset (count below snapshot) yields the count itself.
module cnt_delta_sat
   import cnt_mon_pkg::*;
#(
   parameter int DW = DEF_DW
) (
   input  logic [63:0]   i_count,
   input  logic [63:0]   i_snap,
   output logic [DW-1:0] o_delta
);
   logic [63:0] w_diff;
   assign w_diff  = (i_count < i_snap) ? i_count : i_count - i_snap;
   assign o_delta = (w_diff > sat_max(DW)) ? '1 : w_diff[DW-1:0];
endmodule

// File: rtl/count_window_monitor.sv
// count_window_monitor: per-window count deltas with threshold flags, reported over a valid/ack record.
// Define CNT_MON_PEAK_EN to add o_peak0/o_peak1 (max delta since reset or start).
module count_window_monitor
   import cnt_mon_pkg::*;
#(
   parameter int unsigned WINDOW = DEF_WINDOW,
   parameter int          DW     = DEF_DW
) (
   input  logic                   clk,
   input  logic                   rst,
   count_window_monitor_if.master rpt,
   input  logic                   i_start,
   input  logic                   i_stop,
   input  logic [63:0]            i_count0,
   input  logic [63:0]            i_count1,
   input  logic [DW-1:0]          i_thresh0,
   input  logic [DW-1:0]          i_thresh1,
   output logic                   o_busy
`ifdef CNT_MON_PEAK_EN
   ,
   output logic [DW-1:0]          o_peak0,
   output logic [DW-1:0]          o_peak1
`endif
);
   state_t r_state, w_next;
   logic [31:0] r_timer;
   logic [63:0] r_snap0, r_snap1;
   logic [DW-1:0] w_delta0, w_delta1, r_delta0, r_delta1;
   logic r_valid, r_over0, r_over1, r_lost;
   logic w_win_end, w_free, w_take;

   cnt_delta_sat #(.DW(DW)) u_sat0 (.i_count(i_count0), .i_snap(r_snap0), .o_delta(w_delta0));
   cnt_delta_sat #(.DW(DW)) u_sat1 (.i_count(i_count1), .i_snap(r_snap1), .o_delta(w_delta1));

   // A Stop on the closing cycle discards that window as well
   assign w_win_end = (r_state == RUN) && (r_timer == WINDOW - 1) && !i_stop;
   assign w_take    = r_valid && rpt.rpt_ack;
   assign w_free    = !r_valid || rpt.rpt_ack;

   always_comb begin
      w_next = i_stop ? IDLE : (r_state == IDLE) ? (i_start ? ARM : IDLE) : RUN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_timer  <= '0;
         r_snap0  <= '0;
         r_snap1  <= '0;
         r_valid  <= 1'b0;
         r_delta0 <= '0;
         r_delta1 <= '0;
         r_over0  <= 1'b0;
         r_over1  <= 1'b0;
         r_lost   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_timer <= (r_state == RUN && !w_win_end) ? r_timer + 32'd1 : '0;
         if (r_state == ARM || w_win_end) begin
            r_snap0 <= i_count0;
            r_snap1 <= i_count1;
         end
         if (w_win_end && w_free) begin
            r_valid  <= 1'b1;
            r_delta0 <= w_delta0;
            r_delta1 <= w_delta1;
            r_over0  <= w_delta0 > i_thresh0;
            r_over1  <= w_delta1 > i_thresh1;
         end else if (w_take) begin
            r_valid <= 1'b0;
         end
         r_lost <= (w_win_end && !w_free) || (r_lost && !w_take);
      end
   end

`ifdef CNT_MON_PEAK_EN
   logic [DW-1:0] r_peak0, r_peak1;
   always_ff @(posedge clk) begin
      if (rst || r_state == ARM) begin
         r_peak0 <= '0;
         r_peak1 <= '0;
      end else if (w_win_end) begin
         r_peak0 <= (w_delta0 > r_peak0) ? w_delta0 : r_peak0;
         r_peak1 <= (w_delta1 > r_peak1) ? w_delta1 : r_peak1;
      end
   end
   assign o_peak0 = r_peak0;
   assign o_peak1 = r_peak1;
`endif

   assign o_busy         = r_state != IDLE;
   assign rpt.rpt_valid  = r_valid;
   assign rpt.rpt_delta0 = r_delta0;
   assign rpt.rpt_delta1 = r_delta1;
   assign rpt.rpt_over0  = r_over0;
   assign rpt.rpt_over1  = r_over1;
   assign rpt.rpt_lost   = r_lost;
endmodule

// File: tb/tb_count_window_monitor.sv
// tb_count_window_monitor: directed and randomized stimulus checked against a window-level reference model.
module tb_count_window_monitor;
   localparam int unsigned W = 10;
   localparam int DW = 32;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
   logic [63:0] c0 = '0, c1 = '0;
   logic [DW-1:0] th0 = '0, th1 = '0;
   logic busy;
`ifdef CNT_MON_PEAK_EN
   logic [DW-1:0] pk0, pk1;
`endif

   count_window_monitor_if #(.DW(DW)) rif ();

   count_window_monitor #(.WINDOW(W), .DW(DW)) dut (
      .clk(clk), .rst(rst), .rpt(rif),
      .i_start(start), .i_stop(stop),
      .i_count0(c0), .i_count1(c1),
      .i_thresh0(th0), .i_thresh1(th1),
      .o_busy(busy)
`ifdef CNT_MON_PEAK_EN
      , .o_peak0(pk0), .o_peak1(pk1)
`endif
   );

   always #5 clk = ~clk;

   // Reference: mode 0 idle, 1 arming, 2 running; m_cyc = cycles elapsed in current window
   int m_mode = 0;
   int unsigned m_cyc = 0;
   logic [63:0] m_s0 = '0, m_s1 = '0;
   logic m_v = 1'b0, m_o0 = 1'b0, m_o1 = 1'b0, m_lost = 1'b0;
   logic [DW-1:0] m_d0 = '0, m_d1 = '0, m_pk0 = '0, m_pk1 = '0;
   int n_tests = 0, n_fail = 0;

   function automatic logic [DW-1:0] dsat(input logic [63:0] c, input logic [63:0] s);
      logic [63:0] d;
      if (c < s) d = c;
      else d = c - s;
      return ((d >> DW) != 0) ? '1 : d[DW-1:0];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic ack);
      logic r_i, st_i, sp_i, we, fr;
      logic [DW-1:0] d0, d1;
      rif.rpt_ack = ack;
      r_i = rst;
      st_i = start;
      sp_i = stop;
      we = (m_mode == 2) && (m_cyc == W - 1) && !sp_i;
      d0 = dsat(c0, m_s0);
      d1 = dsat(c1, m_s1);
      fr = !m_v || ack;
      @(posedge clk);
      #1;
      if (r_i) begin
         m_mode = 0; m_cyc = 0; m_s0 = '0; m_s1 = '0; m_v = 0; m_o0 = 0; m_o1 = 0;
         m_lost = 0; m_d0 = '0; m_d1 = '0; m_pk0 = '0; m_pk1 = '0;
      end else begin
         if (we && !fr) m_lost = 1'b1;
         else if (m_v && ack) m_lost = 1'b0;
         if (we && fr) begin
            m_v = 1'b1; m_d0 = d0; m_d1 = d1; m_o0 = d0 > th0; m_o1 = d1 > th1;
         end else if (m_v && ack) m_v = 1'b0;
         if (m_mode == 1) begin
            m_pk0 = '0; m_pk1 = '0;
         end else if (we) begin
            if (d0 > m_pk0) m_pk0 = d0;
            if (d1 > m_pk1) m_pk1 = d1;
         end
         if (m_mode == 1 || we) begin
            m_s0 = c0; m_s1 = c1;
         end
         m_cyc = (m_mode == 2 && !sp_i && !we) ? m_cyc + 1 : 0;
         m_mode = sp_i ? 0 : (m_mode == 0) ? (st_i ? 1 : 0) : 2;
      end
      start = 1'b0;
      stop = 1'b0;
      check("busy", busy, m_mode != 0);
      check("valid", rif.rpt_valid, m_v);
      check("lost", rif.rpt_lost, m_lost);
      check("delta0", rif.rpt_delta0, m_d0);
      check("delta1", rif.rpt_delta1, m_d1);
      check("over0", rif.rpt_over0, m_o0);
      check("over1", rif.rpt_over1, m_o1);
`ifdef CNT_MON_PEAK_EN
      check("peak0", pk0, m_pk0);
      check("peak1", pk1, m_pk1);
`endif
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int g;
      int r;
      logic got_sat;
      rif.rpt_ack = 1'b0;
      repeat (2) tick(0);
      rst = 1'b0;
      tick(0);
      // steady counting, immediate acks, boundary thresholds
      th0 = 9;
      th1 = 3;
      start = 1'b1;
      for (int k = 0; k < 50; k++) begin
         c0 += 1;
         if (k % 4 == 0) c1 += 1;
         tick(1);
         if (rif.rpt_valid) begin
            check("tp_delta0", rif.rpt_delta0, 10);
            check("tp_over0", rif.rpt_over0, 1);
            check("tp_over1", rif.rpt_over1, 0);
         end
      end
      // consumer stalls across several windows
      for (int k = 0; k < 35; k++) begin
         c0 += 1;
         tick(0);
      end
      check("stall_lost", rif.rpt_lost, 1);
      c0 += 1;
      tick(1);
      // saturation and upstream counter reset
      got_sat = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (k == 3) c0 += 64'h100_0000_0000;
         else if (k == 17) c0 = '0;
         else c0 += 1;
         tick(1);
         got_sat = got_sat || (rif.rpt_valid && rif.rpt_delta0 == 32'hFFFF_FFFF);
      end
      check("sat_seen", got_sat, 1);
      // stop partway through a window, then start/stop collision in idle
      g = 0;
      while (m_cyc != 5 && g < 40) begin
         c0 += 1;
         tick(1);
         g++;
      end
      check("wait_t5", g < 40, 1);
      stop = 1'b1;
      tick(1);
      check("stop_busy", busy, 0);
      repeat (12) tick(1);
      check("stop_no_rpt", rif.rpt_valid, 0);
      start = 1'b1;
      stop = 1'b1;
      tick(1);
      check("startstop_idle", busy, 0);
      start = 1'b1;
      for (int k = 0; k < 25; k++) begin
         c0 += 2;
         tick(1);
      end
      // ack landing on the window-end cycle
      for (int k = 0; k < 12; k++) begin
         c0 += 1;
         tick(0);
      end
      g = 0;
      while (m_cyc != W - 1 && g < 40) begin
         c0 += 1;
         tick(0);
         g++;
      end
      check("wait_end", g < 40, 1);
      c0 += 7;
      tick(1);
      check("coinc_valid", rif.rpt_valid, 1);
      check("coinc_lost", rif.rpt_lost, 0);
      // randomized traffic
      for (int k = 0; k < 900; k++) begin
         r = int'($urandom_range(0, 99));
         if (r == 0) c0 = '0;
         else if (r == 1) c0 += 64'd1 << $urandom_range(30, 44);
         else c0 += 64'($urandom_range(0, 3));
         r = int'($urandom_range(0, 99));
         if (r == 0) c1 = '0;
         else c1 += 64'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) begin
            th0 = DW'($urandom_range(0, 40));
            th1 = DW'($urandom_range(0, 12));
         end
         start = $urandom_range(0, 19) == 0;
         stop = $urandom_range(0, 79) == 0;
         tick($urandom_range(0, 2) != 0);
      end
      // reset in the middle of operation
      start = 1'b1;
      for (int k = 0; k < 14; k++) begin
         c0 += 3;
         tick(0);
      end
      rst = 1'b1;
      tick(0);
      check("rst_valid", rif.rpt_valid, 0);
      rst = 1'b0;
      tick(0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
